mips_cpu: RTL and testbench
===========================

Name: mips_cpu

Overview:
- Single-cycle, MIPS-like 32-bit integer CPU.
- The program arrives on a flat 32768-bit instruction bus (1024 words), which acts as read-only instruction memory.
- The block holds the PC, a 32x32 register file, and HI/LO multiply registers. It has no data memory and no architectural outputs.
- Benches check results by reading internal state hierarchically: regs[0:31], pc, hi, lo.

Parameters:
- IMEM_WORDS, 1024, number of instruction words carried on instruction_stream.
- PC_W, 10, width of the word-index program counter (log2 IMEM_WORDS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instruction_stream  input  32768  program image; word i = bits [32*i+31 : 32*i].

Behaviour:
- Reset, sampled on the rising clk edge while rst=1:
  - pc=0, all regs=0, hi=0, lo=0.
  - No instruction executes during a reset cycle.
- Execution:
  - Each rising edge with rst=0 fully executes the instruction at word pc. The combinational fetch is instruction_stream word pc.
  - Register, HI/LO and pc writes all take effect at that edge. Latency is 1 cycle per instruction, with no pipeline and no hazards.
- PC:
  - Default next pc = pc+1, with word indexing.
  - pc wraps from 1023 to 0.
- Register $0 always reads 0. Writes to $0 are discarded.
- Fields:
  - op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sh=[10:6], fn=[5:0], imm=[15:0].
  - simm = sign-extended imm; zimm = zero-extended imm.
- R-type (op=000000), result to rd:
  - add 100000 / addu 100001: rs+rt.
  - sub 100010 / subu 100011: rs-rt.
  - and 100100, or 100101, xor 100110, nor 100111.
  - slt 101010 (signed) and sltu 101011 (unsigned): result 1 or 0.
  - sll 000000: rt<<sh. srl 000010: rt>>sh, logical. sra 000011: rt>>>sh, arithmetic.
  - mult 011000: {hi,lo} = signed rs*rt, 64-bit. multu 011001: unsigned product. Neither writes a GPR.
  - mfhi 010000: rd=hi. mflo 010010: rd=lo.
  - jr 001000: pc = rs[9:0]. No GPR write.
- I-type, result to rt:
  - addi 001000 / addiu 001001: rs+simm.
  - slti 001010: signed rs<simm gives 1, else 0.
  - andi 001100, ori 001101, xori 001110: operand is zimm.
  - lui 001111: {imm,16'h0}.
  - seq 011000: rt = (rs == simm) ? 1 : 0.
- Branches and jumps (no GPR write, no delay slots):
  - beq 000100: if rs==rt, pc = pc+1+simm, truncated to 10 bits.
  - bne 000101: if rs!=rt, same target as beq.
  - j 000010: pc = instr[9:0].
- Arithmetic:
  - All 32-bit arithmetic wraps modulo 2^32. No overflow traps.
  - Shift amount comes from sh only.
- Unknown opcode/funct: no-op, only pc advances. An all-zero word (sll $0,$0,0) is a no-op.
- Reset asserted mid-program: the next edge restores the reset state. Execution resumes at word 0 on the first edge after rst falls.
- Reads use pre-edge register values. An instruction reading and writing the same register (add $1,$1,$1) uses the old value.

Test Plan:
- Reset: hold rst=1 for 1 edge -> pc=0, regs/hi/lo all 0. Program of all zero words for 5 cycles -> regs unchanged, pc=5.
- Reference program at words 0..6:
  - addi $1,$0,2; add $1,$1,$1; addi $2,$0,7; mult $1,$2; mflo $3; srl $3,$3,3; seq $1,$3,3 (encoded 0x60610003).
  - After 7 edges: $1=1, $2=7, $3=3, hi=0, lo=28, pc=7.
  - Intermediate checks: $1=4 after edge 2; $3=28 after edge 5.
- Signed/unsigned multiply:
  - addi $1,$0,-3; addi $2,$0,5; mult -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - multu on the same operands -> hi=4, lo=0xFFFFFFF1.
- $0 and wrap:
  - addi $0,$0,5 -> $0 stays 0.
  - lui $1,0x7FFF; ori $1,$1,0xFFFF; addi $1,$1,1 -> $1=0x80000000, no trap.
- Control flow:
  - beq $0,$0,+2 at word 0 -> next pc=3.
  - bne with equal operands -> pc+1.
  - j 10 -> pc=10.
  - Program falling off word 1023 -> pc=0.
- Mid-run reset: assert rst for 1 edge during the reference program -> all regs 0, pc=0. The program reruns to the same final values.

Source files
------------

// File: rtl/mips_cpu.sv
// Single-cycle MIPS-like 32-bit integer core fetching from a flat read-only instruction bus.
// One instruction retires per rising clk edge; there are no stalls and no pipeline.
module mips_cpu #(
    parameter int IMEM_WORDS = 1024,
    parameter int PC_W       = 10
) (
    input logic                       clk,
    input logic                       rst,
    input logic [32*IMEM_WORDS-1:0]   instruction_stream
);
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [31:0]     regs [0:31];
    logic [PC_W-1:0] pc;
    logic [31:0]     hi;
    logic [31:0]     lo;

    logic [31:0]     instr;
    logic [5:0]      op, fn;
    logic [4:0]      rs, rt, rd, sh;
    logic [15:0]     imm;
    logic [31:0]     simm, zimm, rs_val, rt_val;
    logic [63:0]     prod_s, prod_u;
    logic [PC_W-1:0] pc_inc, br_tgt;

    logic [PC_W-1:0] pc_d;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [31:0]     wr_dat;
    logic            hilo_we;
    logic [31:0]     hi_d, lo_d;

    assign instr  = instruction_stream[{pc, 5'd0} +: 32];
    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign sh     = instr[10:6];
    assign fn     = instr[5:0];
    assign imm    = instr[15:0];
    assign simm   = {{16{imm[15]}}, imm};
    assign zimm   = {16'h0000, imm};
    // regs[0] is never written, so it always reads as zero
    assign rs_val = regs[rs];
    assign rt_val = regs[rt];
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'h0, rs_val} * {32'h0, rt_val};
    assign pc_inc = pc + PC_ONE;
    assign br_tgt = pc_inc + simm[PC_W-1:0];

    always_comb begin
        pc_d    = pc_inc;
        wr_en   = 1'b0;
        wr_addr = rd;
        wr_dat  = '0;
        hilo_we = 1'b0;
        hi_d    = hi;
        lo_d    = lo;
        case (op)
            6'h00: begin
                wr_en = 1'b1;
                case (fn)
                    6'h20, 6'h21: wr_dat = rs_val + rt_val;
                    6'h22, 6'h23: wr_dat = rs_val - rt_val;
                    6'h24:        wr_dat = rs_val & rt_val;
                    6'h25:        wr_dat = rs_val | rt_val;
                    6'h26:        wr_dat = rs_val ^ rt_val;
                    6'h27:        wr_dat = ~(rs_val | rt_val);
                    6'h2a:        wr_dat = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    6'h2b:        wr_dat = {31'h0, rs_val < rt_val};
                    6'h00:        wr_dat = rt_val << sh;
                    6'h02:        wr_dat = rt_val >> sh;
                    6'h03:        wr_dat = $signed(rt_val) >>> sh;
                    6'h10:        wr_dat = hi;
                    6'h12:        wr_dat = lo;
                    6'h18: begin
                        wr_en   = 1'b0;
                        hilo_we = 1'b1;
                        {hi_d, lo_d} = prod_s;
                    end
                    6'h19: begin
                        wr_en   = 1'b0;
                        hilo_we = 1'b1;
                        {hi_d, lo_d} = prod_u;
                    end
                    6'h08: begin
                        wr_en = 1'b0;
                        pc_d  = rs_val[PC_W-1:0];
                    end
                    default:      wr_en = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin wr_en = 1'b1; wr_addr = rt; wr_dat = rs_val + simm; end
            6'h0a: begin wr_en = 1'b1; wr_addr = rt; wr_dat = {31'h0, $signed(rs_val) < $signed(simm)}; end
            6'h0c: begin wr_en = 1'b1; wr_addr = rt; wr_dat = rs_val & zimm; end
            6'h0d: begin wr_en = 1'b1; wr_addr = rt; wr_dat = rs_val | zimm; end
            6'h0e: begin wr_en = 1'b1; wr_addr = rt; wr_dat = rs_val ^ zimm; end
            6'h0f: begin wr_en = 1'b1; wr_addr = rt; wr_dat = {imm, 16'h0000}; end
            6'h18: begin wr_en = 1'b1; wr_addr = rt; wr_dat = {31'h0, rs_val == simm}; end
            6'h04: if (rs_val == rt_val) pc_d = br_tgt;
            6'h05: if (rs_val != rt_val) pc_d = br_tgt;
            6'h02: pc_d = instr[PC_W-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
            hi <= '0;
            lo <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            pc <= pc_d;
            if (hilo_we) begin
                hi <= hi_d;
                lo <= lo_d;
            end
            if (wr_en && (wr_addr != 5'd0)) regs[wr_addr] <= wr_dat;
        end
    end
endmodule

// File: tb/tb_mips_cpu.sv
// Directed and randomized bench for mips_cpu; architectural state is observed hierarchically.
module tb_mips_cpu;
    logic           clk;
    logic           rst;
    logic [32767:0] prog;

    int checks;
    int failures;

    logic [31:0] m_regs [32];
    logic [9:0]  m_pc;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mips_cpu dut (
        .clk                (clk),
        .rst                (rst),
        .instruction_stream (prog)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        prog[32*i +: 32] = w;
    endtask

    function automatic logic [31:0] rtype(input int fn, input int rs, input int rt, input int rd, input int sh);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < 32; i++) chk($sformatf("%s_r%0d", tag, i), dut.regs[i], 32'h0);
        chk({tag, "_hi"}, dut.hi, 32'h0);
        chk({tag, "_lo"}, dut.lo, 32'h0);
        chk({tag, "_pc"}, 32'(dut.pc), 32'h0);
    endtask

    task automatic load_reference();
        prog = '0;
        set_word(0, itype(8, 0, 1, 2));
        set_word(1, rtype(6'h20, 1, 1, 1, 0));
        set_word(2, itype(8, 0, 2, 7));
        set_word(3, rtype(6'h18, 1, 2, 0, 0));
        set_word(4, rtype(6'h12, 0, 0, 3, 0));
        set_word(5, rtype(6'h02, 0, 3, 3, 3));
        set_word(6, 32'h60610003);
    endtask

    task automatic chk_reference_final(input string tag);
        chk({tag, "_r1"}, dut.regs[1], 32'd1);
        chk({tag, "_r2"}, dut.regs[2], 32'd7);
        chk({tag, "_r3"}, dut.regs[3], 32'd3);
        chk({tag, "_hi"}, dut.hi, 32'd0);
        chk({tag, "_lo"}, dut.lo, 32'd28);
        chk({tag, "_pc"}, 32'(dut.pc), 32'd7);
    endtask

    // Instruction semantics written directly from the ISA rules using plain integer arithmetic.
    task automatic m_exec(input logic [31:0] ins);
        int unsigned     a, b;
        int              sa, sb, simm, sh;
        longint          ps, sxa, sxb;
        longint unsigned pu, uxa, uxb;
        logic [4:0]      rs, rt, rd;
        logic [9:0]      nxt;
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        sh   = int'(ins[10:6]);
        a    = m_regs[rs];
        b    = m_regs[rt];
        sa   = int'(a);
        sb   = int'(b);
        simm = int'($signed(ins[15:0]));
        nxt  = 10'(int'(m_pc) + 1);
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20, 6'h21: m_regs[rd] = 32'(a + b);
                6'h22, 6'h23: m_regs[rd] = 32'(a - b);
                6'h24: m_regs[rd] = a & b;
                6'h25: m_regs[rd] = a | b;
                6'h26: m_regs[rd] = a ^ b;
                6'h27: m_regs[rd] = ~(a | b);
                6'h2a: m_regs[rd] = (sa < sb) ? 32'd1 : 32'd0;
                6'h2b: m_regs[rd] = (a < b) ? 32'd1 : 32'd0;
                6'h00: m_regs[rd] = 32'(b << sh);
                6'h02: m_regs[rd] = 32'(b >> sh);
                6'h03: m_regs[rd] = 32'(sb >>> sh);
                6'h18: begin
                    sxa = sa; sxb = sb; ps = sxa * sxb;
                    m_hi = ps[63:32]; m_lo = ps[31:0];
                end
                6'h19: begin
                    uxa = a; uxb = b; pu = uxa * uxb;
                    m_hi = pu[63:32]; m_lo = pu[31:0];
                end
                6'h10: m_regs[rd] = m_hi;
                6'h12: m_regs[rd] = m_lo;
                6'h08: nxt = a[9:0];
                default: ;
            endcase
            6'h08, 6'h09: m_regs[rt] = 32'(sa + simm);
            6'h0a: m_regs[rt] = (sa < simm) ? 32'd1 : 32'd0;
            6'h0c: m_regs[rt] = a & 32'(ins[15:0]);
            6'h0d: m_regs[rt] = a | 32'(ins[15:0]);
            6'h0e: m_regs[rt] = a ^ 32'(ins[15:0]);
            6'h0f: m_regs[rt] = {ins[15:0], 16'h0000};
            6'h18: m_regs[rt] = (sa == simm) ? 32'd1 : 32'd0;
            6'h04: if (a == b) nxt = 10'(int'(m_pc) + 1 + simm);
            6'h05: if (a != b) nxt = 10'(int'(m_pc) + 1 + simm);
            6'h02: nxt = ins[9:0];
            default: ;
        endcase
        m_regs[0] = 32'h0;
        m_pc = nxt;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pc = '0;
        m_hi = '0;
        m_lo = '0;
    endtask

    function automatic logic [31:0] gen_instr();
        int k;
        int rfn [19] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, 'h2b,
                         'h00, 'h02, 'h03, 'h18, 'h19, 'h10, 'h12, 'h08, 'h3f};
        int iop [8]  = '{'h08, 'h09, 'h0a, 'h0c, 'h0d, 'h0e, 'h0f, 'h18};
        int imm;
        k = int'($urandom_range(0, 9));
        if (k <= 3)
            return rtype(rfn[$urandom_range(0, 18)], int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 31)));
        if (k <= 7) begin
            imm = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535));
            return itype(iop[$urandom_range(0, 7)], int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), imm);
        end
        if (k == 8) begin
            case ($urandom_range(0, 2))
                0: return itype(4, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 12)) - 4);
                1: return itype(5, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 12)) - 4);
                default: return {6'h02, 26'($urandom_range(0, 1023))};
            endcase
        end
        return $urandom;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst      = 1'b1;
        prog     = '0;

        // Reset state, then an all-zero program is a string of no-ops
        tick(1);
        rst = 1'b0;
        chk_all_zero("reset");
        tick(5);
        chk("nop_pc", 32'(dut.pc), 32'd5);
        for (int i = 0; i < 32; i++) chk($sformatf("nop_r%0d", i), dut.regs[i], 32'h0);

        // Reference program
        load_reference();
        do_reset();
        tick(2);
        chk("ref_r1_e2", dut.regs[1], 32'd4);
        tick(3);
        chk("ref_r3_e5", dut.regs[3], 32'd28);
        tick(2);
        chk_reference_final("ref");

        // Signed vs unsigned multiply of -3 and 5
        prog = '0;
        set_word(0, itype(8, 0, 1, -3));
        set_word(1, itype(8, 0, 2, 5));
        set_word(2, rtype(6'h18, 1, 2, 0, 0));
        set_word(3, rtype(6'h19, 1, 2, 0, 0));
        do_reset();
        tick(3);
        chk("mult_hi", dut.hi, 32'hFFFFFFFF);
        chk("mult_lo", dut.lo, 32'hFFFFFFF1);
        tick(1);
        chk("multu_hi", dut.hi, 32'h00000004);
        chk("multu_lo", dut.lo, 32'hFFFFFFF1);

        // $0 stays zero; signed overflow wraps silently
        prog = '0;
        set_word(0, itype(8, 0, 0, 5));
        set_word(1, itype(6'h0f, 0, 1, 16'h7FFF));
        set_word(2, itype(6'h0d, 1, 1, 16'hFFFF));
        set_word(3, itype(8, 1, 1, 1));
        do_reset();
        tick(1);
        chk("r0_write", dut.regs[0], 32'h0);
        tick(3);
        chk("wrap_r1", dut.regs[1], 32'h80000000);
        chk("wrap_pc", 32'(dut.pc), 32'd4);

        // Control flow
        prog = '0;
        set_word(0, itype(4, 0, 0, 2));
        do_reset();
        tick(1);
        chk("beq_taken_pc", 32'(dut.pc), 32'd3);
        set_word(0, itype(5, 0, 0, 2));
        do_reset();
        tick(1);
        chk("bne_not_taken_pc", 32'(dut.pc), 32'd1);
        set_word(0, {6'h02, 26'd10});
        do_reset();
        tick(1);
        chk("j_pc", 32'(dut.pc), 32'd10);
        set_word(0, {6'h02, 26'd1020});
        do_reset();
        tick(1);
        chk("j_far_pc", 32'(dut.pc), 32'd1020);
        tick(4);
        chk("pc_wrap", 32'(dut.pc), 32'd0);

        // Mid-run reset, then the program reruns to the same result
        load_reference();
        do_reset();
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_all_zero("midrst");
        tick(7);
        chk_reference_final("rerun");

        // Random programs covering the whole image, compared edge by edge
        for (int w = 0; w < 1024; w++) set_word(w, gen_instr());
        do_reset();
        m_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                m_reset();
            end else begin
                m_exec(prog[32*m_pc +: 32]);
                tick(1);
            end
            chk($sformatf("rand_pc_c%0d", c), 32'(dut.pc), 32'(m_pc));
            chk($sformatf("rand_hi_c%0d", c), dut.hi, m_hi);
            chk($sformatf("rand_lo_c%0d", c), dut.lo, m_lo);
            for (int i = 0; i < 32; i++)
                chk($sformatf("rand_r%0d_c%0d", i, c), dut.regs[i], m_regs[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
